// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: register index width, the per-stage record
// and the default width of the stall-cycle counter.
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W   = 3;
  localparam int STALL_CNT_W = 16;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One in-flight instruction as seen by the hazard logic
  typedef struct packed {
    logic     v;
    reg_idx_t dst;
    logic     wr;
  } stage_rec_t;

  localparam stage_rec_t STAGE_BUBBLE = '0;

  // True when the stage holds a live instruction that will write idx
  function automatic logic produces(input stage_rec_t s, input reg_idx_t idx);
    return s.v & s.wr & (s.dst == idx);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side request, memory/branch control and the controller's
// stall, kill, load-enable and stage-status outputs.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
);

  logic             D_valid;
  reg_idx_t         D_src1_idx;
  logic             D_src1_used;
  reg_idx_t         D_src2_idx;
  logic             D_src2_used;
  reg_idx_t         D_dst_idx;
  logic             D_writes;
  logic             M_busy;
  logic             E_flush;

  logic             D_stall;
  logic             D_kill;
  logic             E_ld;
  logic             E_valid;
  logic             M_valid;
  logic             WB_valid;
  reg_idx_t         WB_dst_idx;
  logic             WB_wr_en;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline side: presents decode state, consumes stall/kill decisions
  modport master (
    output D_valid, D_src1_idx, D_src1_used, D_src2_idx, D_src2_used,
           D_dst_idx, D_writes, M_busy, E_flush,
    input  D_stall, D_kill, E_ld, E_valid, M_valid, WB_valid,
           WB_dst_idx, WB_wr_en, stall_cnt
  );

  // Controller side
  modport slave (
    input  D_valid, D_src1_idx, D_src1_used, D_src2_idx, D_src2_used,
           D_dst_idx, D_writes, M_busy, E_flush,
    output D_stall, D_kill, E_ld, E_valid, M_valid, WB_valid,
           WB_dst_idx, WB_wr_en, stall_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Compares one decode source operand against the E, M and WB stage records.
// There is no bypass network, so a pending write in any stage is a hazard.
module hazard_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  reg_idx_t   src_idx,
  input  logic       src_used,
  input  stage_rec_t e_rec,
  input  stage_rec_t m_rec,
  input  stage_rec_t wb_rec,
  output logic       match
);

  assign match = src_used & (produces(e_rec, src_idx) |
                             produces(m_rec, src_idx) |
                             produces(wb_rec, src_idx));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the D/E/M/WB pipeline: tracks the producers in
// E, M and WB, stalls decode on read-after-write, handles memory
// back-pressure and branch flush, and counts decode stall cycles.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = STALL_CNT_W
)(
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);

  stage_rec_t       e_q, m_q, wb_q;
  stage_rec_t       e_d, m_d, wb_d;
  logic             match1, match2, hazard;
  logic             d_stall, e_ld;
  logic [CNT_W-1:0] cnt_q;

  hazard_match u_match_src1 (
    .src_idx  (bus.D_src1_idx),
    .src_used (bus.D_src1_used),
    .e_rec    (e_q),
    .m_rec    (m_q),
    .wb_rec   (wb_q),
    .match    (match1)
  );

  hazard_match u_match_src2 (
    .src_idx  (bus.D_src2_idx),
    .src_used (bus.D_src2_used),
    .e_rec    (e_q),
    .m_rec    (m_q),
    .wb_rec   (wb_q),
    .match    (match2)
  );

  assign hazard = bus.D_valid & (match1 | match2);

  // Priority mux: memory back-pressure freezes E/M, then flush, then RAW bubble, then normal issue
  always_comb begin
    e_d     = e_q;
    m_d     = m_q;
    wb_d    = wb_q;
    d_stall = 1'b0;
    e_ld    = 1'b1;
    if (rst) begin
      e_d  = STAGE_BUBBLE;
      m_d  = STAGE_BUBBLE;
      wb_d = STAGE_BUBBLE;
    end else if (bus.M_busy) begin
      wb_d    = STAGE_BUBBLE;
      d_stall = 1'b1;
      e_ld    = 1'b0;
    end else if (bus.E_flush) begin
      e_d  = STAGE_BUBBLE;
      m_d  = e_q;
      wb_d = m_q;
    end else if (hazard) begin
      e_d     = STAGE_BUBBLE;
      m_d     = e_q;
      wb_d    = m_q;
      d_stall = 1'b1;
    end else begin
      e_d  = '{v: bus.D_valid, dst: bus.D_dst_idx, wr: bus.D_writes & bus.D_valid};
      m_d  = e_q;
      wb_d = m_q;
    end
  end

  // Stage records advance only through the priority mux
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q  <= STAGE_BUBBLE;
      m_q  <= STAGE_BUBBLE;
      wb_q <= STAGE_BUBBLE;
    end else begin
      e_q  <= e_d;
      m_q  <= m_d;
      wb_q <= wb_d;
    end
  end

  // Saturating count of cycles where a real decode instruction was held
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (bus.D_valid && d_stall && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.D_stall    = d_stall;
  assign bus.D_kill     = bus.E_flush;
  assign bus.E_ld       = e_ld;
  assign bus.E_valid    = e_q.v;
  assign bus.M_valid    = m_q.v;
  assign bus.WB_valid   = wb_q.v;
  assign bus.WB_dst_idx = wb_q.dst;
  assign bus.WB_wr_en   = wb_q.v & wb_q.wr;
  assign bus.stall_cnt  = cnt_q;

endmodule
